// File: rtl/multiplier_control_if.sv
// Handshake bundle between the add/shift multiplier controller and its operator/datapath side.
interface multiplier_control_if;
   logic run;
   logic cleara_loadb;
   logic m;
   logic clr_ld;
   logic cleara;
   logic add;
   logic sub;
   logic shift;
   logic busy;
   logic done;

   modport master (
      output run, cleara_loadb, m,
      input  clr_ld, cleara, add, sub, shift, busy, done
   );

   modport slave (
      input  run, cleara_loadb, m,
      output clr_ld, cleara, add, sub, shift, busy, done
   );
endinterface

// File: rtl/multiplier_control.sv
// Sequencer for a signed add/shift multiplier: NUM_BITS add+shift iterations, subtract on the last.
// Optional feature: define MULT_CTRL_AUTOCLEAR_EN to clear A/X at the start of every multiply.
module multiplier_control #(
   parameter int NUM_BITS = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   multiplier_control_if.slave  bus
);

   localparam int KW = (NUM_BITS > 2) ? $clog2(NUM_BITS) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NUM_BITS - 1);

   typedef enum logic [2:0] {IDLE, CLEAR, ADD, SHIFT, HOLD} state_t;

   state_t        state, state_nxt;
   logic [KW-1:0] k, k_nxt;
   logic          run_prev;
   logic          start;

   // run_prev resets high so a Run level held through reset release is not an edge
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         k        <= '0;
         run_prev <= 1'b1;
      end else begin
         state    <= state_nxt;
         k        <= k_nxt;
         run_prev <= bus.run;
      end
   end

   always_comb begin
      state_nxt    = state;
      k_nxt        = k;
      start        = 1'b0;
      bus.clr_ld   = 1'b0;
      bus.cleara   = 1'b0;
      bus.add      = 1'b0;
      bus.sub      = 1'b0;
      bus.shift    = 1'b0;
      bus.busy     = 1'b0;
      bus.done     = 1'b0;
      case (state)
         IDLE: begin
            start = bus.run & ~run_prev;
            if (start) begin
               k_nxt = '0;
`ifdef MULT_CTRL_AUTOCLEAR_EN
               state_nxt = CLEAR;
`else
               state_nxt = ADD;
`endif
            end else begin
               bus.clr_ld = bus.cleara_loadb;
            end
         end
         CLEAR: begin
`ifdef MULT_CTRL_AUTOCLEAR_EN
            bus.cleara = 1'b1;
`endif
            bus.busy  = 1'b1;
            k_nxt     = '0;
            state_nxt = ADD;
         end
         ADD: begin
            // the top multiplier bit carries negative weight, hence subtract on the last pass
            bus.busy  = 1'b1;
            bus.add   = bus.m & (k != K_LAST);
            bus.sub   = bus.m & (k == K_LAST);
            state_nxt = SHIFT;
         end
         SHIFT: begin
            bus.busy  = 1'b1;
            bus.shift = 1'b1;
            if (k == K_LAST) begin
               state_nxt = HOLD;
            end else begin
               k_nxt     = k + 1'b1;
               state_nxt = ADD;
            end
         end
         HOLD: begin
            bus.done = 1'b1;
            if (!bus.run) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_multiplier_control.sv
// Scoreboard bench: per-cycle strobe expectations and products derived from the multiply rules.
module tb_multiplier_control;

   localparam int N = 8;
`ifdef MULT_CTRL_AUTOCLEAR_EN
   localparam int AC = 1;
`else
   localparam int AC = 0;
`endif

   typedef struct packed {
      logic clr_ld, cleara, add, sub, shift, busy, done;
   } outv_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   multiplier_control_if ifc();

   multiplier_control #(.NUM_BITS(N)) dut (.clk(clk), .reset_n(reset_n), .bus(ifc));

   always #5 clk = ~clk;

   // behavioural datapath: 9-bit adder X:A, multiplier B, multiplicand S
   logic [7:0] a, b, s, sw;
   logic       x;
   always_ff @(posedge clk) begin
      if (ifc.clr_ld) begin a <= '0; x <= 1'b0; b <= sw; end
      else if (ifc.cleara) begin a <= '0; x <= 1'b0; end
      else if (ifc.add) {x, a} <= {a[7], a} + {s[7], s};
      else if (ifc.sub) {x, a} <= {a[7], a} - {s[7], s};
      else if (ifc.shift) {x, a, b} <= {x, x, a, b[7:1]};
   end
   assign ifc.m = b[0];

   outv_t       exp_q[$];
   logic [15:0] prod_q[$];
   int          checks = 0;
   int          errors = 0;
   bit          async_flag = 0;
   bit          end_flag = 0;
   logic        async_clb = 0;
   event        async_chk;

   function automatic outv_t mk(input logic cl, ca, ad, su, sh, bu, dn);
      outv_t v;
      v = '{clr_ld:cl, cleara:ca, add:ad, sub:su, shift:sh, busy:bu, done:dn};
      return v;
   endfunction

   task automatic cyc(input logic r, input logic c, input outv_t e);
      ifc.run = r;
      ifc.cleara_loadb = c;
      exp_q.push_back(e);
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, mk(0,0,0,0,0,0,0));
   endtask

   task automatic load(input logic [7:0] bv);
      sw = bv;
      cyc(1'b0, 1'b1, mk(1,0,0,0,0,0,0));
      idle(1);
   endtask

   // mode 0: Run held high, no load requests; mode 1: Run/ClearA_LoadB random while busy
   task automatic op(input logic [7:0] bv, input logic [7:0] sv, input int mode,
                     input int hold_extra, input bit chk_prod);
      logic [15:0] p;
      logic rr, rc;
      s = sv;
      p = 16'($signed(sv) * $signed(bv));
      if (chk_prod) prod_q.push_back(p);
      rc = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      cyc(1'b1, rc, mk(0,0,0,0,0,0,0));
      for (int t = 0; t < 2*N + AC; t++) begin
         rr = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
         rc = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
         if (t < AC) cyc(rr, rc, mk(0,1,0,0,0,1,0));
         else if (((t - AC) % 2) == 0) begin
            int i;
            i = (t - AC) / 2;
            cyc(rr, rc, mk(0,0, bv[i] & (i < N-1), bv[i] & (i == N-1), 0,1,0));
         end else cyc(rr, rc, mk(0,0,0,0,1,1,0));
      end
      for (int h = 0; h < hold_extra; h++)
         cyc(1'b1, (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0, mk(0,0,0,0,0,0,1));
      cyc(1'b0, 1'b0, mk(0,0,0,0,0,0,1));
      idle(1);
   endtask

   // monitor: pops one expectation per falling edge, product on each Done rise
   initial begin : monitor
      outv_t act, e;
      logic  done_d;
      done_d = 1'b0;
      forever begin
         @(negedge clk or async_chk);
         act = {ifc.clr_ld, ifc.cleara, ifc.add, ifc.sub, ifc.shift, ifc.busy, ifc.done};
         if (end_flag) begin
            checks++;
            if (exp_q.size() != 0 || prod_q.size() != 0) begin
               errors++;
               $display("FAIL drain: pending strobes %0d products %0d, required 0 0",
                        exp_q.size(), prod_q.size());
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
         end else if (async_flag) begin
            checks++;
            e = mk(async_clb,0,0,0,0,0,0);
            if (act !== e) begin
               errors++;
               $display("FAIL async_reset: got %b required %b", act, e);
            end
         end else begin
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               checks++;
               if (act !== e) begin
                  errors++;
                  $display("FAIL strobes @%0t: got %b required %b (clr_ld,cleara,add,sub,shift,busy,done)",
                           $time, act, e);
               end
            end
            if (ifc.done && !done_d) begin
               checks++;
               if (prod_q.size() == 0) begin
                  errors++;
                  $display("FAIL product: Done with no operation expected");
               end else begin
                  logic [15:0] pe;
                  pe = prod_q.pop_front();
                  if ({a, b} !== pe) begin
                     errors++;
                     $display("FAIL product: got %h required %h", {a, b}, pe);
                  end
               end
            end
            done_d = ifc.done;
         end
      end
   end

   initial begin : driver
      ifc.run = 1'b1;
      ifc.cleara_loadb = 1'b0;
      sw = 8'h00;
      s = 8'h00;
      // reset state, Run high through release must not start
      @(posedge clk); #1;
      cyc(1'b1, 1'b0, mk(0,0,0,0,0,0,0));
      cyc(1'b1, 1'b1, mk(1,0,0,0,0,0,0));
      reset_n = 1'b1;
      cyc(1'b1, 1'b0, mk(0,0,0,0,0,0,0));
      cyc(1'b1, 1'b0, mk(0,0,0,0,0,0,0));
      idle(2);

      // directed: co-sim products, all-ones and all-zeros multiplier
      load(8'h07); op(8'h07, 8'hFD, 1, 0, 1);
      load(8'h80); op(8'h80, 8'h80, 1, 0, 1);
      load(8'hFF); op(8'hFF, 8'h35, 0, 0, 1);
      load(8'h00); op(8'h00, 8'h7F, 0, 0, 1);
      // Run held high for 40 cycles: one operation, Done persists
      load(8'h5A); op(8'h5A, 8'hC3, 0, 40 - 1 - 2*N - AC, 1);
      idle(3);
      // load request together with the Run edge: start wins (checked inside op, rc may be 1)
      load(8'h11);
      s = 8'h22;
      prod_q.push_back(16'($signed(8'h22) * $signed(8'h11)));
      ifc.run = 1'b1; ifc.cleara_loadb = 1'b1;
      exp_q.push_back(mk(0,0,0,0,0,0,0));
      @(posedge clk); #1;
      for (int t = 0; t < 2*N + AC; t++) begin
         if (t < AC) cyc(1'b0, 1'b1, mk(0,1,0,0,0,1,0));
         else if (((t - AC) % 2) == 0)
            cyc(1'b0, 1'b1, mk(0,0, (((t-AC)/2) == 0 || ((t-AC)/2) == 4) && ((t-AC)/2) < N-1, 1'b0, 0,1,0));
         else cyc(1'b0, 1'b1, mk(0,0,0,0,1,1,0));
      end
      cyc(1'b0, 1'b0, mk(0,0,0,0,0,0,1));
      idle(1);

      // random operations
      for (int r = 0; r < 20; r++) begin
         logic [7:0] bv, sv;
         bv = 8'($urandom);
         sv = 8'($urandom);
         load(bv);
         op(bv, sv, 1, int'($urandom_range(0, 3)), 1);
      end

      // reset in SHIFT at k=4, Run still high afterwards
      load(8'hFF);
      s = 8'h01;
      cyc(1'b1, 1'b0, mk(0,0,0,0,0,0,0));
      if (AC == 1) cyc(1'b1, 1'b0, mk(0,1,0,0,0,1,0));
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 1'b0, mk(0,0,1,0,0,1,0));
         cyc(1'b1, 1'b0, mk(0,0,0,0,1,1,0));
      end
      cyc(1'b1, 1'b0, mk(0,0,1,0,0,1,0));
      ifc.run = 1'b1; ifc.cleara_loadb = 1'b0;
      exp_q.push_back(mk(0,0,0,0,1,1,0));
      #6;
      reset_n = 1'b0;
      #1;
      async_clb = 1'b0;
      async_flag = 1'b1;
      -> async_chk;
      #1;
      async_flag = 1'b0;
      @(posedge clk); #1;
      cyc(1'b1, 1'b0, mk(0,0,0,0,0,0,0));
      cyc(1'b1, 1'b1, mk(1,0,0,0,0,0,0));
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, mk(0,0,0,0,0,0,0));
      idle(1);
      load(8'h03); op(8'h03, 8'h05, 1, 1, 1);
      idle(2);

      end_flag = 1'b1;
      -> async_chk;
      #20;
      $display("FAIL monitor: no summary produced");
      $fatal(1);
   end

endmodule
